// File: rtl/serial_frame_deserializer.sv
// Hunts a serial bit stream for SYNC_PAT, then deserializes WIDTH-bit payloads MSB-first, re-checking sync on every frame.
// Latency: dout_valid rises one cycle after the edge that samples the last payload bit.
// Backpressure: one-entry output buffer; a word that completes while the buffer is held is dropped and sets sticky overflow.
module serial_frame_deserializer #(
    parameter int                WIDTH    = 8,
    parameter int                SYNC_W   = 8,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             locked,
    output logic             sync_err,
    output logic             overflow,
    input  logic             ovf_clr
);
    localparam int MAXW = (WIDTH > SYNC_W) ? WIDTH : SYNC_W;
    localparam int CW   = $clog2(MAXW + 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CHK_LAST  = CW'(SYNC_W - 1);

    typedef enum logic [1:0] {HUNT, DATA, CHECK} state_t;

    state_t            state, state_nx;
    logic [SYNC_W-1:0] sh, sh_nx, sh_shift;
    logic [WIDTH-1:0]  word, word_nx, word_shift;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              word_done;
    logic              sync_miss;

    assign sh_shift   = {sh[SYNC_W-2:0], din};
    assign word_shift = {word[WIDTH-2:0], din};
    assign locked     = (state != HUNT);

    always_comb begin
        state_nx  = state;
        sh_nx     = sh;
        word_nx   = word;
        cnt_nx    = cnt;
        word_done = 1'b0;
        sync_miss = 1'b0;
        if (din_en) begin
            case (state)
                HUNT: begin
                    sh_nx = sh_shift;
                    if (sh_shift == SYNC_PAT) begin
                        state_nx = DATA;
                        cnt_nx   = '0;
                    end
                end
                DATA: begin
                    word_nx = word_shift;
                    cnt_nx  = cnt + 1'b1;
                    if (cnt == DATA_LAST) begin
                        word_done = 1'b1;
                        state_nx  = CHECK;
                        cnt_nx    = '0;
                        sh_nx     = '0;
                    end
                end
                CHECK: begin
                    sh_nx  = sh_shift;
                    cnt_nx = cnt + 1'b1;
                    if (cnt == CHK_LAST) begin
                        cnt_nx = '0;
                        if (sh_shift == SYNC_PAT) begin
                            state_nx = DATA;
                        end else begin
                            // shifter keeps the mismatched bits so hunting can overlap them
                            state_nx  = HUNT;
                            sync_miss = 1'b1;
                        end
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            sh    <= '0;
            word  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sh    <= sh_nx;
            word  <= word_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            sync_err <= sync_miss;
            if (word_done && (!dout_valid || dout_ready)) begin
                dout       <= word_shift;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            // a drop in the same cycle as a clear leaves overflow set
            if (word_done && dout_valid && !dout_ready) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Scenario bench for serial_frame_deserializer: directed framing cases plus a randomized stream
// checked against a frame-level reference model computed from the sent bits.
module tb_serial_frame_deserializer;
    localparam logic [7:0] PAT = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       din = 1'b0;
    logic       din_en = 1'b0;
    logic       dout_ready = 1'b1;
    logic       ovf_clr = 1'b0;
    logic [7:0] dout;
    logic       dout_valid, locked, sync_err, overflow;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         err_cnt = 0;
    logic [7:0] got_q[$];
    int         got_t[$];
    bit         stream[$];
    logic [7:0] exp_q[$];

    serial_frame_deserializer #(.WIDTH(8), .SYNC_W(8), .SYNC_PAT(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .locked(locked), .sync_err(sync_err), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // words are recorded when they will be accepted at the coming edge
    always @(negedge clk) begin
        if (rst_n && dout_valid && dout_ready) begin
            got_q.push_back(dout);
            got_t.push_back(cyc);
        end
        if (sync_err) err_cnt++;
    end

    // Frame-level reference: slide a window until it equals the pattern, then alternate payload/sync fields.
    function automatic int ref_model();
        logic [7:0] win, chk, pay;
        int i, nerr;
        bit lk;
        exp_q.delete();
        win = '0; chk = '0; pay = '0; i = 0; nerr = 0; lk = 1'b0;
        while (i < stream.size()) begin
            if (!lk) begin
                win = {win[6:0], stream[i]};
                i++;
                lk = (win == PAT);
            end else begin
                if (i + 8 > stream.size()) break;
                for (int k = 0; k < 8; k++) pay = {pay[6:0], stream[i+k]};
                exp_q.push_back(pay);
                i += 8;
                if (i + 8 > stream.size()) break;
                for (int k = 0; k < 8; k++) chk = {chk[6:0], stream[i+k]};
                i += 8;
                if (chk != PAT) begin
                    nerr++;
                    win = chk;
                    lk = 1'b0;
                end
            end
        end
        return nerr;
    endfunction

    task automatic send_bit(input logic b);
        din = b;
        din_en = 1'b1;
        stream.push_back(b);
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic idle(input int n);
        din_en = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        din = 1'b0; din_en = 1'b0; dout_ready = 1'b1; ovf_clr = 1'b0;
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
        stream.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL reset_sync_err got=%b exp=0", sync_err); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lock();
        logic [4:0] r;
        logic [7:0] v;
        int gb;
        do_reset();
        gb = got_q.size();
        do r = 5'($urandom); while (r == 5'b10100);
        for (int i = 4; i >= 0; i--) send_bit(r[i]);
        for (int i = 7; i >= 1; i--) send_bit(PAT[i]);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_early got=%b exp=0", locked); end
        send_bit(PAT[0]);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_rise got=%b exp=1", locked); end
        v = 8'h3C;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL lock_valid_early got=%b exp=0", dout_valid); end
        send_bit(v[0]);
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL lock_valid got=%b exp=1", dout_valid); end
        checks++; if (dout !== 8'h3C) begin failures++; $display("FAIL lock_dout got=%h exp=3c", dout); end
        idle(1);
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL lock_valid_one_cycle got=%b exp=0", dout_valid); end
        checks++; if (got_q.size() - gb != 1) begin failures++; $display("FAIL lock_word_count got=%0d exp=1", got_q.size() - gb); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[3];
        int gb, eb;
        exp = '{8'h11, 8'h22, 8'h33};
        do_reset();
        gb = got_q.size();
        eb = err_cnt;
        for (int f = 0; f < 3; f++) begin
            send_byte(PAT);
            send_byte(exp[f]);
        end
        idle(2);
        checks++;
        if (got_q.size() - gb != 3) begin
            failures++; $display("FAIL b2b_count got=%0d exp=3", got_q.size() - gb);
        end else begin
            for (int f = 0; f < 3; f++) begin
                checks++; if (got_q[gb+f] !== exp[f]) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", f, got_q[gb+f], exp[f]); end
            end
            for (int f = 1; f < 3; f++) begin
                checks++; if (got_t[gb+f] - got_t[gb+f-1] != 16) begin failures++; $display("FAIL b2b_spacing%0d got=%0d exp=16", f, got_t[gb+f] - got_t[gb+f-1]); end
            end
        end
        checks++; if (err_cnt - eb != 0) begin failures++; $display("FAIL b2b_sync_err got=%0d exp=0", err_cnt - eb); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL b2b_locked got=%b exp=1", locked); end
    endtask

    task automatic test_sync_loss();
        logic [7:0] v;
        int gb, eb;
        do_reset();
        gb = got_q.size();
        eb = err_cnt;
        send_byte(PAT);
        send_byte(8'h44);
        v = 8'hA4;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL loss_err_early got=%b exp=0", sync_err); end
        send_bit(v[0]);
        checks++; if (sync_err !== 1'b1) begin failures++; $display("FAIL loss_err_pulse got=%b exp=1", sync_err); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL loss_locked got=%b exp=0", locked); end
        send_byte(8'h55);
        send_byte(PAT);
        send_byte(8'h66);
        idle(1);
        checks++; if (dout !== 8'h66) begin failures++; $display("FAIL loss_relock_dout got=%h exp=66", dout); end
        checks++; if (err_cnt - eb != 1) begin failures++; $display("FAIL loss_err_count got=%0d exp=1", err_cnt - eb); end
        checks++;
        if (got_q.size() - gb != 2) begin
            failures++; $display("FAIL loss_word_count got=%0d exp=2", got_q.size() - gb);
        end else begin
            checks++; if (got_q[gb] !== 8'h44) begin failures++; $display("FAIL loss_word0 got=%h exp=44", got_q[gb]); end
            checks++; if (got_q[gb+1] !== 8'h66) begin failures++; $display("FAIL loss_word1 got=%h exp=66", got_q[gb+1]); end
        end
    endtask

    task automatic test_overflow();
        int gb;
        do_reset();
        gb = got_q.size();
        dout_ready = 1'b0;
        send_byte(PAT);
        send_byte(8'h01);
        checks++; if (dout_valid !== 1'b1 || dout !== 8'h01) begin failures++; $display("FAIL ovf_first got=%b/%h exp=1/01", dout_valid, dout); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", overflow); end
        send_byte(PAT);
        send_byte(8'h02);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        checks++; if (dout_valid !== 1'b1 || dout !== 8'h01) begin failures++; $display("FAIL ovf_hold got=%b/%h exp=1/01", dout_valid, dout); end
        idle(1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
        checks++; if (got_q.size() != gb) begin failures++; $display("FAIL ovf_no_accept got=%0d exp=0", got_q.size() - gb); end
        dout_ready = 1'b1;
        idle(1);
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL ovf_release_valid got=%b exp=0", dout_valid); end
        checks++;
        if (got_q.size() - gb != 1) begin
            failures++; $display("FAIL ovf_release_count got=%0d exp=1", got_q.size() - gb);
        end else begin
            checks++; if (got_q[gb] !== 8'h01) begin failures++; $display("FAIL ovf_release_word got=%h exp=01", got_q[gb]); end
        end
    endtask

    task automatic test_din_en_gaps();
        logic [15:0] v;
        int t0;
        do_reset();
        v = {PAT, 8'h7E};
        t0 = cyc;
        for (int i = 15; i >= 0; i--) begin
            idle(1);
            if (i == 0) begin
                checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL gap_valid_early got=%b exp=0", dout_valid); end
            end
            send_bit(v[i]);
        end
        checks++; if (cyc - t0 != 32) begin failures++; $display("FAIL gap_latency got=%0d exp=32", cyc - t0); end
        checks++; if (dout_valid !== 1'b1 || dout !== 8'h7E) begin failures++; $display("FAIL gap_word got=%b/%h exp=1/7e", dout_valid, dout); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL gap_locked got=%b exp=1", locked); end
    endtask

    task automatic test_async_reset();
        logic [7:0] v;
        int gb;
        do_reset();
        gb = got_q.size();
        send_byte(PAT);
        send_byte(8'h5A);
        send_byte(PAT);
        v = 8'hC3;
        for (int i = 7; i >= 4; i--) send_bit(v[i]);
        checks++; if (locked !== 1'b1 || dout !== 8'h5A) begin failures++; $display("FAIL arst_pre got=%b/%h exp=1/5a", locked, dout); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL arst_dout got=%h exp=00", dout); end
        checks++; if (locked !== 1'b0 || dout_valid !== 1'b0) begin failures++; $display("FAIL arst_flags got=%b/%b exp=0/0", locked, dout_valid); end
        checks++; if (sync_err !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL arst_err got=%b/%b exp=0/0", sync_err, overflow); end
        #2 rst_n = 1'b1;
        stream.delete();
        @(posedge clk); #1;
        for (int i = 3; i >= 0; i--) send_bit(v[i]);
        send_byte(PAT);
        send_byte(8'h96);
        idle(2);
        checks++;
        if (got_q.size() - gb != 2) begin
            failures++; $display("FAIL arst_word_count got=%0d exp=2", got_q.size() - gb);
        end else begin
            checks++; if (got_q[gb+1] !== 8'h96) begin failures++; $display("FAIL arst_rehunt got=%h exp=96", got_q[gb+1]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] s, p;
        int gb, eb, nerr, nj;
        logic [15:0] fr;
        do_reset();
        gb = got_q.size();
        eb = err_cnt;
        nj = $urandom_range(0, 6);
        for (int i = 0; i < nj; i++) send_bit(1'($urandom));
        for (int f = 0; f < 10; f++) begin
            s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : PAT;
            p = 8'($urandom);
            fr = {s, p};
            for (int i = 15; i >= 0; i--) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                send_bit(fr[i]);
            end
        end
        idle(2);
        nerr = ref_model();
        checks++; if (err_cnt - eb != nerr) begin failures++; $display("FAIL rand_sync_errs got=%0d exp=%0d", err_cnt - eb, nerr); end
        checks++;
        if (got_q.size() - gb != exp_q.size()) begin
            failures++; $display("FAIL rand_word_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++; if (got_q[gb+k] !== exp_q[k]) begin failures++; $display("FAIL rand_word%0d got=%h exp=%h", k, got_q[gb+k], exp_q[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_back_to_back();
        test_sync_loss();
        test_overflow();
        test_din_en_gaps();
        test_async_reset();
        for (int r = 0; r < 4; r++) test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_frame_deserializer.md
Name: serial_frame_deserializer

Overview:
- Downstream consumer of the single-bit registered/inverted serial stage (`clk`/`di`/`do` flop pipeline).
- Hunts the stream for a fixed sync pattern, then deserializes fixed-width payload words MSB-first.
- Presents words through a one-entry valid/ready output buffer.
- Re-checks sync on every frame, drops lock on mismatch, and flags overflow when the buffer is still occupied.

Parameters:
- WIDTH, 8, payload bits per frame (2..32)
- SYNC_W, 8, sync pattern length in bits (2..16)
- SYNC_PAT, 8'hA5, sync pattern, SYNC_W bits, MSB transmitted first

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- din  input  1  serial bit from the upstream stage
- din_en  input  1  qualifies din; bit is consumed only when high
- dout  output  WIDTH  deserialized payload word
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  downstream accepts the word when high with dout_valid
- locked  output  1  frame alignment established
- sync_err  output  1  one-cycle pulse on sync mismatch while locked
- overflow  output  1  sticky: a completed word was dropped
- ovf_clr  input  1  clears overflow

Behaviour:
- Reset (rst_n low, asynchronous): outputs and state are cleared.
  - dout=0, dout_valid=0, locked=0, sync_err=0, overflow=0.
  - FSM=HUNT, sync shifter=0, bit counter=0.
- All state below advances only on edges where din_en=1. Exceptions, which act every edge:
  - the dout handshake
  - sync_err deassertion
  - ovf_clr
- Sync shifter (SYNC_W bits): value = {shifter[SYNC_W-2:0], din}. It shifts in HUNT and CHECK; it is held in DATA.
- FSM states:
  - HUNT: locked=0. If the shifted-in value equals SYNC_PAT, go to DATA with counter=0; otherwise stay in HUNT. Overlapping matches are allowed.
  - DATA: locked=1. din shifts into the payload register, MSB first, and the counter increments.
    - On the WIDTH-th bit, the word completes. Go to CHECK with counter=0 and sync shifter=0.
  - CHECK: locked=1. Counter increments per bit. On the SYNC_W-th bit, compare the shifted-in value with SYNC_PAT:
    - equal: go to DATA, counter=0
    - not equal: go to HUNT, sync_err=1 for exactly one clk; the shifter keeps its value.
- Word completion, taking effect at the edge sampling the last payload bit:
  - If dout_valid=0, or dout_valid&&dout_ready at that same edge: dout<=word and dout_valid<=1.
  - Otherwise the word is dropped, dout is unchanged, and overflow<=1.
- Latency: dout_valid rises the cycle after the edge that samples the last payload bit.
- Handshake: dout_valid && dout_ready at an edge with no completing word clears dout_valid. dout stays stable while valid and not accepted.
- Overflow precedence: ovf_clr clears overflow. If ovf_clr and a new drop occur at the same edge, set wins.
- Frame length: SYNC_W + WIDTH bits. The first frame needs only a HUNT match; later frames require the exact position.
- din_en low mid-frame pauses the counter and shifters with no timeout; state is preserved.
- rst_n asserted mid-frame aborts the frame immediately. A partially shifted word is never emitted.
- Counter width: clog2(max(WIDTH, SYNC_W)+1). No wrap, since the counter is reset on every state change.

Test Plan (WIDTH=8, SYNC_W=8, SYNC_PAT=8'hA5, din_en=1, dout_ready=1 unless noted):
1. Random 5 bits, then A5, 3C. Required:
   - locked rises the cycle after the 8th A5 bit.
   - dout=8'h3C, dout_valid=1 for one cycle, starting the cycle after the 8th 3C bit.
2. Frames A5 11, A5 22, A5 33 back-to-back. Required:
   - dout sequence 11, 22, 33, each 16 cycles apart.
   - sync_err=0 and locked stays 1.
3. A5 44, then A4 55. Required:
   - sync_err pulses once after the 8th bit of A4.
   - locked=0 and 55 is not emitted.
   - Then A5 66 produces dout=66.
4. dout_ready=0, frames A5 01, A5 02. Required:
   - dout holds 01 and dout_valid stays 1.
   - overflow=1 after the 02 completion.
   - Then ovf_clr=1 for one cycle: overflow=0.
   - Then dout_ready=1 releases dout=01.
5. din_en toggled 0/1 every other cycle during A5 7E. Required: dout=7E arrives after 32 clk, with identical framing.
6. rst_n pulsed low, asynchronously between edges, after 4 payload bits of frame A5 C3. Required:
   - All outputs are 0 immediately.
   - No C3 is emitted.
   - Re-hunt succeeds on the next A5.
